// File: rtl/bsg_pipeline_credit_drain_pkg.sv
// Shared helpers for the credit-drain pipeline controller and its sub-blocks.
package bsg_pipeline_credit_drain_pkg;

  // clog2 that never returns 0, so single-entry structures still get a 1-bit field.
  function automatic int unsigned safe_clog2(input int unsigned x);
    return (x <= 1) ? 1 : $clog2(x);
  endfunction

endpackage

// File: rtl/bsg_counter_up_down.sv
// Up/down occupancy counter; simultaneous up and down leave the count unchanged.
module bsg_counter_up_down
  import bsg_pipeline_credit_drain_pkg::*;
#(
  parameter int unsigned max_val_p = 1
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                up_i,
  input  logic                                down_i,
  output logic [safe_clog2(max_val_p+1)-1:0]  count_o
);

  localparam int unsigned cnt_width_lp = safe_clog2(max_val_p + 1);

  logic [cnt_width_lp-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (reset_i)                count_q <= '0;
    else if (up_i && !down_i)   count_q <= count_q + 1'b1;
    else if (down_i && !up_i)   count_q <= count_q - 1'b1;
  end

  assign count_o = count_q;

endmodule

// File: rtl/bsg_dff_reset.sv
// Plain register bank with synchronous active-high reset to zero.
module bsg_dff_reset #(
  parameter int unsigned width_p = 1
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  output logic [width_p-1:0] data_o
);

  logic [width_p-1:0] data_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) data_q <= '0;
    else         data_q <= data_i;
  end

  assign data_o = data_q;

endmodule

// File: rtl/bsg_fifo_1r1w_small.sv
// Small in-order FIFO; head is registered, no enq->v_o bypass when empty.
module bsg_fifo_1r1w_small
  import bsg_pipeline_credit_drain_pkg::*;
#(
  parameter int unsigned width_p = 8,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int unsigned ptr_width_lp = safe_clog2(els_p);
  localparam int unsigned cnt_width_lp = safe_clog2(els_p + 1);
  localparam logic [ptr_width_lp-1:0] last_ptr_lp = ptr_width_lp'(els_p - 1);

  logic [width_p-1:0]      mem_q [els_p];
  logic [ptr_width_lp-1:0] wr_ptr_q, rd_ptr_q;
  logic [cnt_width_lp-1:0] cnt_q;
  logic                    enq, deq;

  assign enq = v_i;
  assign deq = yumi_i & v_o;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (enq) wr_ptr_q <= (wr_ptr_q == last_ptr_lp) ? '0 : wr_ptr_q + 1'b1;
      if (deq) rd_ptr_q <= (rd_ptr_q == last_ptr_lp) ? '0 : rd_ptr_q + 1'b1;
      if (enq && !deq)      cnt_q <= cnt_q + 1'b1;
      else if (deq && !enq) cnt_q <= cnt_q - 1'b1;
    end
  end

  // Storage needs no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk_i) begin
    if (enq) mem_q[wr_ptr_q] <= data_i;
  end

  assign ready_o = (cnt_q != cnt_width_lp'(els_p));
  assign v_o     = (cnt_q != '0);
  assign data_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/bsg_pipeline_credit_drain.sv
// Drain-end controller for a non-stallable pipeline: credits gate the entrance so every
// admitted item is guaranteed a tail FIFO slot when it emerges.
module bsg_pipeline_credit_drain
  import bsg_pipeline_credit_drain_pkg::*;
#(
  parameter int unsigned width_p  = 8,
  parameter int unsigned stages_p = 3,
  parameter int unsigned els_p    = 4
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                valid_i,
  output logic                ready_and_o,
  output logic [stages_p-1:0] en_o,
  output logic [stages_p-1:0] valid_o,
  input  logic [width_p-1:0]  data_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  input  logic                ready_and_i
);

  localparam int unsigned cnt_width_lp = safe_clog2(els_p + 1);

  logic [cnt_width_lp-1:0] cnt_q;
  logic [stages_p-1:0]     v_q, v_d;
  logic                    accept, enq, deq, fifo_ready;

  // Credit is derived from registered state only; ready_and_i never reaches ready_and_o.
  assign ready_and_o = (cnt_q != cnt_width_lp'(els_p)) & ~reset_i;
  assign accept      = valid_i & ready_and_o;
  assign deq         = v_o & ready_and_i;
  assign enq         = v_q[0];

  bsg_counter_up_down #(
    .max_val_p (els_p)
  ) u_credit_cnt (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (accept),
    .down_i  (deq),
    .count_o (cnt_q)
  );

  if (stages_p == 1) begin : g_single
    assign v_d = accept;
  end else begin : g_multi
    assign v_d = {accept, v_q[stages_p-1:1]};
  end

  bsg_dff_reset #(
    .width_p (stages_p)
  ) u_valid_regs (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .data_i  (v_d),
    .data_o  (v_q)
  );

  // A stage loads exactly when a valid item moves into it; bubbles leave data untouched.
  assign en_o    = v_d;
  assign valid_o = v_q;

  bsg_fifo_1r1w_small #(
    .width_p (width_p),
    .els_p   (els_p)
  ) u_tail_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (enq),
    .data_i  (data_i),
    .ready_o (fifo_ready),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (deq)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) assert (!(enq && !fifo_ready && !deq));
  end

endmodule

// File: tb/tb_bsg_pipeline_credit_drain.sv
// Directed bench: two instances (els_p=4 and els_p=2, stages_p=3) sharing producer/consumer.
module tb_bsg_pipeline_credit_drain;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       valid_in = 1'b0;
  logic       ready_in = 1'b0;
  logic [7:0] data_in = '0;

  logic       rdy_a, v_a, rdy_b, v_b;
  logic [2:0] en_a, vld_a, en_b, vld_b;
  logic [7:0] tail_a, dout_a, tail_b, dout_b;
  logic [7:0] pipe_a [3];
  logic [7:0] pipe_b [3];

  int total = 0;
  int bad = 0;
  int acc_a = 0;
  int acc_b = 0;
  logic [7:0] out_a [$];
  logic [7:0] out_b [$];
  logic       s_rdy_a, s_v_a, s_rdy_b, s_vld_b0;
  logic [2:0] s_en_a, s_vld_a, s_en_b;

  always #5 clk = ~clk;

  bsg_pipeline_credit_drain #(.width_p(8), .stages_p(3), .els_p(4)) dut_a (
    .clk_i (clk), .reset_i (reset), .valid_i (valid_in), .ready_and_o (rdy_a),
    .en_o (en_a), .valid_o (vld_a), .data_i (tail_a), .v_o (v_a), .data_o (dout_a),
    .ready_and_i (ready_in)
  );

  bsg_pipeline_credit_drain #(.width_p(8), .stages_p(3), .els_p(2)) dut_b (
    .clk_i (clk), .reset_i (reset), .valid_i (valid_in), .ready_and_o (rdy_b),
    .en_o (en_b), .valid_o (vld_b), .data_i (tail_b), .v_o (v_b), .data_o (dout_b),
    .ready_and_i (ready_in)
  );

  // External datapath registers driven by the controller's enables.
  always @(posedge clk) begin
    if (en_a[2]) pipe_a[2] <= data_in;
    if (en_a[1]) pipe_a[1] <= pipe_a[2];
    if (en_a[0]) pipe_a[0] <= pipe_a[1];
    if (en_b[2]) pipe_b[2] <= data_in;
    if (en_b[1]) pipe_b[1] <= pipe_b[2];
    if (en_b[0]) pipe_b[0] <= pipe_b[1];
  end
  assign tail_a = pipe_a[0];
  assign tail_b = pipe_b[0];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // One cycle: sample at negedge, then return just after the next rising edge.
  task automatic tick();
    @(negedge clk);
    s_rdy_a = rdy_a; s_v_a = v_a; s_en_a = en_a; s_vld_a = vld_a;
    s_rdy_b = rdy_b; s_en_b = en_b; s_vld_b0 = vld_b[0];
    if (valid_in && rdy_a) acc_a++;
    if (valid_in && rdy_b) acc_b++;
    if (v_a && ready_in) out_a.push_back(dout_a);
    if (v_b && ready_in) out_b.push_back(dout_b);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; valid_in = 1'b0; ready_in = 1'b0;
    tick(); tick();
    reset = 1'b0;
    out_a.delete(); out_b.delete();
    acc_a = 0; acc_b = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1; valid_in = 1'b1; ready_in = 1'b1;
    tick(); tick();
    total++;
    if (s_rdy_a !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b want=0", s_rdy_a); end
    total++;
    if (s_v_a !== 1'b0) begin bad++; $display("FAIL reset_v got=%b want=0", s_v_a); end
    total++;
    if (s_vld_a !== 3'b000) begin bad++; $display("FAIL reset_valid got=%b want=000", s_vld_a); end
    total++;
    if (s_en_a !== 3'b000) begin bad++; $display("FAIL reset_en got=%b want=000", s_en_a); end
    reset = 1'b0; valid_in = 1'b0;
    tick();
    total++;
    if (s_rdy_a !== 1'b1) begin bad++; $display("FAIL post_reset_ready got=%b want=1", s_rdy_a); end
    total++;
    if (s_rdy_b !== 1'b1) begin bad++; $display("FAIL post_reset_ready_b got=%b want=1", s_rdy_b); end
  endtask

  task automatic test_stream();
    logic rdy_tab [12] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0, 1, 1};
    int first_v;
    do_reset();
    first_v = -1;
    ready_in = 1'b1; valid_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data_in = 8'h10 + 8'(acc_a);
      tick();
      if (s_v_a && first_v < 0) first_v = c;
      total++;
      if (s_rdy_a !== rdy_tab[c]) begin
        bad++; $display("FAIL stream_ready cyc=%0d got=%b want=%b", c, s_rdy_a, rdy_tab[c]);
      end
    end
    valid_in = 1'b0;
    for (int c = 12; c < 24; c++) begin
      tick();
      if (s_v_a && first_v < 0) first_v = c;
    end
    total++;
    if (first_v != 4) begin bad++; $display("FAIL stream_latency got=%0d want=4", first_v); end
    total++;
    if (out_a.size() != 10) begin
      bad++; $display("FAIL stream_count got=%0d want=10", out_a.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        total++;
        if (out_a[k] !== 8'h10 + 8'(k)) begin
          bad++; $display("FAIL stream_data idx=%0d got=%h want=%h", k, out_a[k], 8'h10 + 8'(k));
        end
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    ready_in = 1'b0; valid_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data_in = 8'h20 + 8'(c);
      tick();
      total++;
      if (s_rdy_a !== (c < 4)) begin
        bad++; $display("FAIL stall_ready cyc=%0d got=%b want=%b", c, s_rdy_a, c < 4);
      end
    end
    total++;
    if (acc_a != 4) begin bad++; $display("FAIL stall_accepts got=%0d want=4", acc_a); end
    total++;
    if (s_v_a !== 1'b1) begin bad++; $display("FAIL stall_v got=%b want=1", s_v_a); end
  endtask

  task automatic test_credit_return();
    ready_in = 1'b1; valid_in = 1'b1; data_in = 8'h30;
    tick();
    total++;
    if (s_rdy_a !== 1'b0) begin bad++; $display("FAIL credit_same_cycle got=%b want=0", s_rdy_a); end
    total++;
    if (out_a.size() != 1 || out_a[0] !== 8'h20) begin
      bad++; $display("FAIL credit_deq got=%0d items want=1 item 20", out_a.size());
    end
    ready_in = 1'b0; data_in = 8'h31;
    tick();
    total++;
    if (s_rdy_a !== 1'b1) begin bad++; $display("FAIL credit_next_cycle got=%b want=1", s_rdy_a); end
    data_in = 8'h32;
    tick();
    total++;
    if (s_rdy_a !== 1'b0) begin bad++; $display("FAIL credit_refull got=%b want=0", s_rdy_a); end
    valid_in = 1'b0; ready_in = 1'b1;
    for (int c = 0; c < 12; c++) tick();
    total++;
    if (out_a.size() != 5 || out_a[1] !== 8'h21 || out_a[3] !== 8'h23 || out_a[4] !== 8'h31) begin
      bad++; $display("FAIL credit_drain_order got=%0d items want=5 (20,21,22,23,31)", out_a.size());
    end
  endtask

  task automatic test_throttle();
    logic       rdy_tab [12] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
    logic [2:0] en_tab  [12] = '{3'b100, 3'b110, 3'b011, 3'b001, 3'b000, 3'b100,
                                 3'b110, 3'b011, 3'b001, 3'b000, 3'b100, 3'b110};
    do_reset();
    ready_in = 1'b1; valid_in = 1'b1;
    for (int c = 0; c < 12; c++) begin
      data_in = 8'h40 + 8'(acc_b);
      tick();
      total++;
      if (s_rdy_b !== rdy_tab[c]) begin
        bad++; $display("FAIL throttle_ready cyc=%0d got=%b want=%b", c, s_rdy_b, rdy_tab[c]);
      end
      total++;
      if (s_en_b !== en_tab[c]) begin
        bad++; $display("FAIL throttle_en cyc=%0d got=%b want=%b", c, s_en_b, en_tab[c]);
      end
    end
    valid_in = 1'b0;
    for (int c = 0; c < 8; c++) tick();
    total++;
    if (out_b.size() != 6 || out_b[0] !== 8'h40 || out_b[5] !== 8'h45) begin
      bad++; $display("FAIL throttle_data got=%0d items want=6 (40..45)", out_b.size());
    end
  endtask

  task automatic test_bubbles();
    logic       pat     [6] = '{1, 0, 1, 0, 0, 0};
    logic [2:0] vld_tab [6] = '{3'b000, 3'b100, 3'b010, 3'b101, 3'b010, 3'b001};
    logic [2:0] en_tab  [6] = '{3'b100, 3'b010, 3'b101, 3'b010, 3'b001, 3'b000};
    do_reset();
    ready_in = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid_in = pat[c];
      data_in  = pat[c] ? 8'hA1 + 8'(c) : 8'hEE;
      tick();
      total++;
      if (s_vld_a !== vld_tab[c]) begin
        bad++; $display("FAIL bubble_valid cyc=%0d got=%b want=%b", c, s_vld_a, vld_tab[c]);
      end
      total++;
      if (s_en_a !== en_tab[c]) begin
        bad++; $display("FAIL bubble_en cyc=%0d got=%b want=%b", c, s_en_a, en_tab[c]);
      end
    end
    for (int c = 0; c < 4; c++) tick();
    total++;
    if (out_a.size() != 2 || out_a[0] !== 8'hA1 || out_a[1] !== 8'hA3) begin
      bad++; $display("FAIL bubble_order got=%0d items want=2 (a1,a3)", out_a.size());
    end
  endtask

  task automatic test_reset_mid();
    logic pat [4] = '{1, 0, 1, 1};
    do_reset();
    ready_in = 1'b0;
    for (int c = 0; c < 4; c++) begin
      valid_in = pat[c];
      data_in  = 8'h61 + 8'(c);
      tick();
    end
    valid_in = 1'b0; reset = 1'b1;
    tick();
    total++;
    if (s_vld_a !== 3'b110 || s_v_a !== 1'b1) begin
      bad++; $display("FAIL midreset_before valid=%b v=%b want valid=110 v=1", s_vld_a, s_v_a);
    end
    reset = 1'b0; ready_in = 1'b1;
    tick();
    total++;
    if (s_v_a !== 1'b0) begin bad++; $display("FAIL midreset_v got=%b want=0", s_v_a); end
    total++;
    if (s_vld_a !== 3'b000) begin bad++; $display("FAIL midreset_valid got=%b want=000", s_vld_a); end
    total++;
    if (s_rdy_a !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b want=1", s_rdy_a); end
    for (int c = 0; c < 10; c++) tick();
    total++;
    if (out_a.size() != 0) begin
      bad++; $display("FAIL midreset_stale got=%0d items want=0", out_a.size());
    end
  endtask

  initial begin
    @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_credit_return();
    test_throttle();
    test_bubbles();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
